led_matrix_driver: RTL and testbench
====================================

// Module: led_matrix_driver
// PURPOSE
// - Drives the sequencer's 4x4 step-LED matrix by time-multiplexed row scanning.
// - Output-side counterpart of the 4x4 button-matrix scan: same row/column geometry, same index map (index = row*4 + col).
// - Takes a 16-bit step frame plus a playhead position from the sequencer core.
// - Double-buffers the frame, inserts blanking between rows to stop ghosting, and overlays the playhead.
// PARAMETERS
// - DWELL_CYCLES  1200  clk cycles a row is lit (12 MHz -> 100 us/row, 2.5 kHz frame rate). Must be >= 16.
// - BLANK_CYCLES  24    clk cycles all rows off between rows (2 us). Must be >= 1.
// PORTS
// - clk          in   1   system clock (12 MHz)
// - rst          in   1   asynchronous, active-high reset
// - frame_in     in   16  step pattern; bit i = LED index i (row i[3:2], col i[1:0])
// - frame_load   in   1   1-cycle strobe: capture frame_in into shadow buffer
// - playhead     in   4   current step index 0..15
// - playhead_en  in   1   1 = invert the LED at playhead
// - row_outputs  out  4   row select, active-low; at most one bit low
// - col_outputs  out  4   column drive, active-high
// - frame_sync   out  1   1-cycle pulse on the first DRIVE cycle of row 0
// - brightness   in   4   only present under LED_DIM_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset values (async on rst=1, apply immediately even mid-row):
//   - row_outputs=4'hF, col_outputs=4'h0, frame_sync=0.
//   - active frame=0, shadow=0, pending=0.
//   - state=BLANK, row=0, timer=0.
// - FSM states (scan_state_t):
//   - BLANK: rows 4'hF, cols 0, for BLANK_CYCLES cycles. Leaves to DRIVE when timer==BLANK_CYCLES-1; timer then clears.
//   - DRIVE: row_outputs[row]=0, all other bits 1; cols = display[4*row +: 4]. Lasts DWELL_CYCLES cycles.
//     On timer==DWELL_CYCLES-1: row <= row+1 (wraps 3->0), timer clears, state goes to BLANK.
// - Outputs are registered. A row is never low in the same cycle its columns change (blanking guarantees this).
// - display = active ^ (playhead_en ? (16'b1 << playhead) : 0).
//   - playhead and playhead_en are sampled once per row on the BLANK->DRIVE edge and held for the whole dwell.
// - Double buffer:
//   - frame_load writes shadow and sets pending.
//   - Swap (active<=shadow, pending<=0) happens on the BLANK->DRIVE edge when row==0 and pending==1.
//   - The active frame never changes mid-frame.
//   - frame_load on the swap cycle: frame_in bypasses to active directly, and pending stays 0.
//   - Back-to-back loads: the last one wins.
// - frame_sync asserts in the same cycle row_outputs first goes to 4'hE.
// - Timer width: $clog2(max(DWELL_CYCLES, BLANK_CYCLES)). The timer counts up and saturates nowhere; it is always cleared at a state exit.
// - Full frame period = 4*(DWELL_CYCLES+BLANK_CYCLES) cycles.
// CONFIGURATION
// - LED_DIM_EN defined:
//   - Adds a `brightness` port and a 4-bit PWM counter that runs only in DRIVE and clears on entry to DRIVE.
//   - col_outputs = display bits & {4{pwm_cnt <= brightness}}. brightness=15 means full on; 0 means 1/16 duty.
//   - brightness is sampled with playhead on the BLANK->DRIVE edge.
// - LED_DIM_EN undefined: no brightness port and no PWM counter; columns are on for the full dwell.
// STRUCTURE
// - Shared package seq_pkg (already holds the sequencer geometry):
//   - NUM_ROWS=4, NUM_COLS=4, NUM_STEPS=16.
//   - step_idx_t (logic [3:0]), scan_state_t enum {BLANK, DRIVE}.
// - Sub-module led_pwm_gate (counter + compare), instantiated only under LED_DIM_EN.
// - The scan FSM and buffers stay in this module.
// TESTING (DWELL_CYCLES=20, BLANK_CYCLES=4 for sim)
// 1. Reset/scan order:
//    - Release rst, then frame_load frame_in=16'h8421.
//    - Rows go 4'hE,D,B,7 in order, each low exactly 20 cycles with 4 cycles of 4'hF between.
//    - Cols per row are 1,2,4,8 from the second frame onward.
// 2. Double buffer:
//    - Load 16'hFFFF mid-row-1 while active=0.
//    - Rows 1..3 of the current frame still show 0; row 0 of the next frame shows 4'hF. Check frame_sync aligns.
// 3. Playhead:
//    - active=16'h0000, playhead=9, playhead_en=1 -> only row 2 shows cols 4'b0010.
//    - Set active=16'hFFFF -> row 2 shows 4'b1101.
// 4. Swap-cycle collision:
//    - Assert frame_load with 16'h00F0 exactly on the row-0 BLANK->DRIVE edge.
//    - Row 1 of that same frame shows 4'hF, and pending is 0.
// 5. Async reset mid-DRIVE:
//    - Assert rst at cycle 10 of row 2.
//    - Same cycle, outputs go to rows 4'hF, cols 0; after release, scan restarts at BLANK, row 0.
// 6. LED_DIM_EN:
//    - brightness=3, frame 16'hFFFF -> each dwell, cols high 4 of every 16 cycles (pwm 0..3).
//    - brightness=15 -> cols high for the full dwell.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - sequencer geometry, scan state type and row-select helper
package seq_pkg;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;
    localparam int NUM_STEPS = 16;

    typedef logic [3:0] step_idx_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low one-cold row select for the given row.
    function automatic logic [3:0] row_select(input logic [1:0] row);
        logic [3:0] r;
        r      = 4'hF;
        r[row] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// rtl/led_pwm_gate.sv - 4-bit dimming counter with brightness compare
// Ports:
//   clk, rst      clock, async active-high reset
//   clear_i       entry into DRIVE: counter restarts at 0
//   run_i         counter advances while the row is driven
//   brightness_i  compare level for the coming cycle
//   gate_o        1 when the coming cycle's count <= brightness_i
module led_pwm_gate
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic [3:0] brightness_i,
    output logic       gate_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 4'd0;
        end else if (run_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Compare against the next count so the registered column output
    // lines up with the count value of the cycle it is shown in.
    assign gate_o = (cnt_d <= brightness_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_matrix_driver.sv
// rtl/led_matrix_driver.sv - 4x4 step-LED row scanner with double buffer and playhead overlay
// Ports:
//   clk, rst      clock, async active-high reset
//   frame_in      16-bit step pattern, bit i = row i[3:2], col i[1:0]
//   frame_load    1-cycle strobe capturing frame_in into the shadow buffer
//   playhead      current step index, playhead_en inverts that LED
//   row_outputs   active-low row select, col_outputs active-high columns
//   frame_sync    1-cycle pulse on the first driven cycle of row 0
//   brightness    dimming level, present only when LED_DIM_EN is defined
// Build option: LED_DIM_EN adds PWM dimming through led_pwm_gate.
module led_matrix_driver
    import seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 1200,
    parameter int BLANK_CYCLES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] frame_in,
    input  logic        frame_load,
    input  logic [3:0]  playhead,
    input  logic        playhead_en,
    output logic [3:0]  row_outputs,
    output logic [3:0]  col_outputs,
    output logic        frame_sync
`ifdef LED_DIM_EN
    ,
    input  logic [3:0]  brightness
`endif
);

    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

    scan_state_t   state_q;
    logic [1:0]    row_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   active_q;
    logic [15:0]   shadow_q;
    logic          pending_q;
    logic [3:0]    row_out_q;
    logic [3:0]    col_out_q;
    logic          sync_q;

    logic          blank_done;
    logic          drive_done;
    logic          swap_edge;
    logic          do_swap;
    logic [15:0]   active_next;
    logic [15:0]   display;
    logic [3:0]    row_bits;
    logic          gate;

    always_comb begin
        blank_done = (state_q == BLANK) && (timer_q == BLANK_LAST);
        drive_done = (state_q == DRIVE) && (timer_q == DWELL_LAST);
        swap_edge  = blank_done && (row_q == 2'd0);
        // A load landing on the swap edge itself goes straight to active,
        // so it is never left stranded in the shadow for a whole frame.
        do_swap    = swap_edge && (pending_q || frame_load);
        active_next = active_q;
        if (do_swap) begin
            active_next = frame_load ? frame_in : shadow_q;
        end
        display  = active_next ^ (playhead_en ? (16'b1 << playhead) : 16'h0000);
        row_bits = display[{row_q, 2'b00} +: 4];
    end

`ifdef LED_DIM_EN
    logic [3:0] bright_q;
    logic [3:0] disp_row_q;

    led_pwm_gate u_pwm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (blank_done),
        .run_i        (state_q == DRIVE),
        .brightness_i (blank_done ? brightness : bright_q),
        .gate_o       (gate)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_q   <= 4'd0;
            disp_row_q <= 4'd0;
        end else if (blank_done) begin
            bright_q   <= brightness;
            disp_row_q <= row_bits;
        end
    end
`else
    assign gate = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BLANK;
            row_q     <= 2'd0;
            timer_q   <= '0;
            active_q  <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            row_out_q <= 4'hF;
            col_out_q <= 4'h0;
            sync_q    <= 1'b0;
        end else begin
            if (frame_load) begin
                shadow_q <= frame_in;
            end
            if (do_swap) begin
                pending_q <= 1'b0;
            end else if (frame_load) begin
                pending_q <= 1'b1;
            end
            active_q <= active_next;
            sync_q   <= swap_edge;

            case (state_q)
                BLANK: begin
                    if (blank_done) begin
                        state_q   <= DRIVE;
                        timer_q   <= '0;
                        row_out_q <= row_select(row_q);
                        col_out_q <= row_bits & {4{gate}};
                    end else begin
                        timer_q   <= timer_q + TW'(1);
                    end
                end
                DRIVE: begin
                    if (drive_done) begin
                        state_q   <= BLANK;
                        timer_q   <= '0;
                        row_q     <= row_q + 2'd1;
                        row_out_q <= 4'hF;
                        col_out_q <= 4'h0;
                    end else begin
                        timer_q   <= timer_q + TW'(1);
`ifdef LED_DIM_EN
                        col_out_q <= disp_row_q & {4{gate}};
`endif
                    end
                end
                default: begin
                    state_q   <= BLANK;
                    timer_q   <= '0;
                    row_out_q <= 4'hF;
                    col_out_q <= 4'h0;
                end
            endcase
        end
    end

    assign row_outputs = row_out_q;
    assign col_outputs = col_out_q;
    assign frame_sync  = sync_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// tb/tb_led_matrix_driver.sv - directed self-checking bench for led_matrix_driver
module tb_led_matrix_driver;

    localparam int DWELL = 20;
    localparam int BLANK = 4;

    logic        clk;
    logic        rst;
    logic [15:0] frame_in;
    logic        frame_load;
    logic [3:0]  playhead;
    logic        playhead_en;
    logic [3:0]  row_outputs;
    logic [3:0]  col_outputs;
    logic        frame_sync;
`ifdef LED_DIM_EN
    logic [3:0]  brightness;
`endif

    int checks = 0;
    int errors = 0;

    led_matrix_driver #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_load  (frame_load),
        .playhead    (playhead),
        .playhead_en (playhead_en),
        .row_outputs (row_outputs),
        .col_outputs (col_outputs),
        .frame_sync  (frame_sync)
`ifdef LED_DIM_EN
        ,
        .brightness  (brightness)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Follows one row from its first lit cycle through the following blank gap.
    // load_at counts negedges from the first lit cycle (dwell 0..19, blank 20..23).
    task automatic scan_row(input string tag, input logic [3:0] pat, input logic chk_cols,
                            input logic [3:0] exp_cols, input int load_at, input logic [15:0] load_val);
        int n;
        int i;
        int dwell;
        int blank;
        logic [3:0] first_cols;
        logic stable;
        logic clean;
        logic extra_sync;
        n = 0;
        while (row_outputs !== pat && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_row"}, row_outputs, pat);
        if (chk_cols) check({tag, "_cols"}, col_outputs, exp_cols);
        check({tag, "_sync"}, frame_sync, pat == 4'hE);
        first_cols = col_outputs;
        stable = 1'b1;
        clean = 1'b1;
        extra_sync = 1'b0;
        i = 0;
        dwell = 0;
        blank = 0;
        while (row_outputs === pat && dwell < 100) begin
            if (col_outputs !== first_cols) stable = 1'b0;
            if (dwell > 0 && frame_sync) extra_sync = 1'b1;
            frame_load = (i == load_at);
            frame_in   = load_val;
            @(negedge clk);
            dwell++;
            i++;
        end
        while (row_outputs === 4'hF && blank < 100) begin
            if (col_outputs !== 4'h0 || frame_sync) clean = 1'b0;
            frame_load = (i == load_at);
            frame_in   = load_val;
            @(negedge clk);
            blank++;
            i++;
        end
        frame_load = 1'b0;
        check({tag, "_dwell"}, dwell, DWELL);
        check({tag, "_blank"}, blank, BLANK);
        check({tag, "_stable"}, stable, 1'b1);
        check({tag, "_clean"}, {clean, extra_sync}, 2'b10);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        frame_in = 16'h0000;
        frame_load = 1'b0;
        playhead = 4'd0;
        playhead_en = 1'b0;
`ifdef LED_DIM_EN
        brightness = 4'd15;
`endif
        repeat (3) @(negedge clk);
        check("rst_rows", row_outputs, 4'hF);
        check("rst_cols", col_outputs, 4'h0);
        check("rst_sync", frame_sync, 1'b0);

        // Scan order, timing and the 8421 diagonal.
        rst = 1'b0;
        frame_load = 1'b1;
        frame_in = 16'h8421;
        @(negedge clk);
        frame_load = 1'b0;
        scan_row("f1_r0", 4'hE, 1'b0, 4'h0, -1, 16'h0);
        scan_row("f1_r1", 4'hD, 1'b0, 4'h0, -1, 16'h0);
        scan_row("f1_r2", 4'hB, 1'b0, 4'h0, -1, 16'h0);
        scan_row("f1_r3", 4'h7, 1'b0, 4'h0, -1, 16'h0);
        scan_row("f2_r0", 4'hE, 1'b1, 4'h1, -1, 16'h0);
        scan_row("f2_r1", 4'hD, 1'b1, 4'h2, -1, 16'h0);
        scan_row("f2_r2", 4'hB, 1'b1, 4'h4, -1, 16'h0);
        scan_row("f2_r3", 4'h7, 1'b1, 4'h8, -1, 16'h0);

        // Double buffer: loads mid-frame only take effect at the next row 0.
        scan_row("f3_r0", 4'hE, 1'b1, 4'h1, 5, 16'h0000);
        scan_row("f3_r1", 4'hD, 1'b1, 4'h2, -1, 16'h0);
        scan_row("f3_r2", 4'hB, 1'b1, 4'h4, -1, 16'h0);
        scan_row("f3_r3", 4'h7, 1'b1, 4'h8, -1, 16'h0);
        scan_row("f4_r0", 4'hE, 1'b1, 4'h0, -1, 16'h0);
        scan_row("f4_r1", 4'hD, 1'b1, 4'h0, 10, 16'hFFFF);
        scan_row("f4_r2", 4'hB, 1'b1, 4'h0, -1, 16'h0);
        scan_row("f4_r3", 4'h7, 1'b1, 4'h0, -1, 16'h0);
        scan_row("f5_r0", 4'hE, 1'b1, 4'hF, 2, 16'h0000);
        scan_row("f5_r1", 4'hD, 1'b1, 4'hF, -1, 16'h0);
        scan_row("f5_r2", 4'hB, 1'b1, 4'hF, -1, 16'h0);
        scan_row("f5_r3", 4'h7, 1'b1, 4'hF, -1, 16'h0);

        // Playhead at step 9 (row 2, col 1); row 0 of f6 was sampled before enable.
        playhead = 4'd9;
        playhead_en = 1'b1;
        scan_row("f6_r0", 4'hE, 1'b1, 4'h0, 2, 16'hFFFF);
        scan_row("f6_r1", 4'hD, 1'b1, 4'h0, -1, 16'h0);
        scan_row("f6_r2", 4'hB, 1'b1, 4'h2, -1, 16'h0);
        scan_row("f6_r3", 4'h7, 1'b1, 4'h0, -1, 16'h0);
        scan_row("f7_r0", 4'hE, 1'b1, 4'hF, -1, 16'h0);
        scan_row("f7_r1", 4'hD, 1'b1, 4'hF, -1, 16'h0);
        scan_row("f7_r2", 4'hB, 1'b1, 4'hD, -1, 16'h0);
        playhead_en = 1'b0;
        // Load lands on the last blank cycle, i.e. exactly on the row-0 swap edge.
        scan_row("f7_r3", 4'h7, 1'b1, 4'hF, 23, 16'h00F0);
        scan_row("f8_r0", 4'hE, 1'b1, 4'h0, -1, 16'h0);
        check("collide_pending", dut.pending_q, 1'b0);
        scan_row("f8_r1", 4'hD, 1'b1, 4'hF, -1, 16'h0);
        scan_row("f8_r2", 4'hB, 1'b1, 4'h0, -1, 16'h0);
        scan_row("f8_r3", 4'h7, 1'b1, 4'h0, -1, 16'h0);

        // Async reset ten cycles into row 2.
        scan_row("f9_r0", 4'hE, 1'b1, 4'h0, -1, 16'h0);
        scan_row("f9_r1", 4'hD, 1'b1, 4'hF, -1, 16'h0);
        n = 0;
        while (row_outputs !== 4'hB && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_row", row_outputs, 4'hB);
        repeat (10) @(negedge clk);
        check("pre_rst_cols", col_outputs, 4'h0);
        #2 rst = 1'b1;
        #1;
        check("async_rows", row_outputs, 4'hF);
        check("async_cols", col_outputs, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (row_outputs !== 4'hE && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("restart_latency", n, BLANK);
        scan_row("r0_after_rst", 4'hE, 1'b1, 4'h0, 2, 16'hFFFF);
        scan_row("r1_after_rst", 4'hD, 1'b1, 4'h0, -1, 16'h0);
        scan_row("r2_after_rst", 4'hB, 1'b1, 4'h0, -1, 16'h0);
        scan_row("r3_after_rst", 4'h7, 1'b1, 4'h0, -1, 16'h0);

`ifdef LED_DIM_EN
        brightness = 4'd3;
        n = 0;
        while (row_outputs !== 4'hD && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("dim3_row", row_outputs, 4'hD);
        for (int k = 0; k < DWELL; k++) begin
            check($sformatf("dim3_c%0d", k), col_outputs, ((k % 16) <= 3) ? 4'hF : 4'h0);
            @(negedge clk);
        end
        brightness = 4'd15;
        n = 0;
        while (row_outputs !== 4'hB && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("dim15_row", row_outputs, 4'hB);
        for (int k = 0; k < DWELL; k++) begin
            check($sformatf("dim15_c%0d", k), col_outputs, 4'hF);
            @(negedge clk);
        end
`else
        scan_row("full_r0", 4'hE, 1'b1, 4'hF, -1, 16'h0);
        scan_row("full_r1", 4'hD, 1'b1, 4'hF, -1, 16'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
